// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake plus instruction-memory write port
// and status flags of the instruction-memory loader. Clock and reset stay
// outside the interface as plain ports.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 9
);
    logic                  start;
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  rx_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;
    logic                  cpu_hold;
    logic                  done;
    logic                  err;

    // Host side: requests sessions and supplies the byte stream.
    modport master (
        output start, rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, err
    );

    // Loader side.
    modport slave (
        input  start, rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed byte stream (LEN_LO, LEN_HI, then
// N little-endian 32-bit words) and writes the words into instruction memory
// starting at BASE_ADDR, holding the core in reset while loading.
// Optional feature macro IMEM_LOADER_CHECKSUM_EN: one trailing byte is
// compared against the XOR of all payload bytes before reporting done.
module imem_loader #(
    parameter int ADDR_WIDTH = 9,
    parameter int BASE_ADDR  = 0
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus
);
    localparam int                    MEM_SIZE = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERR
    } state_t;

    state_t                state_q;
    logic [15:0]           len_q;
    logic [15:0]           cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           shift_q;
    logic [1:0]            byte_cnt_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            csum_q;
`endif
    logic                  rx_ready_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [31:0]           wdata_q;
    logic                  hold_q;
    logic                  done_q;
    logic                  err_q;

    logic                  accept;
    logic [15:0]           len_d;
    logic                  len_bad;
    logic [31:0]           word_d;
    logic [15:0]           cnt_d;

    // Byte acceptance and next values derived from the incoming byte.
    always_comb begin
        accept  = bus.rx_valid & rx_ready_q;
        len_d   = {bus.rx_data, len_q[7:0]};
        len_bad = (len_d == 16'd0) || (int'(len_d) > MEM_SIZE);
        word_d  = {bus.rx_data, shift_q[31:8]};
        cnt_d   = cnt_q + 16'd1;
    end

    // Session FSM; all outputs are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            addr_q     <= BASE;
            shift_q    <= '0;
            byte_cnt_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
            rx_ready_q <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= BASE;
            wdata_q    <= '0;
            hold_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (bus.start) begin
                        state_q    <= LEN_LO;
                        rx_ready_q <= 1'b1;
                        hold_q     <= 1'b1;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                    end else begin
                        // Ends the hold that covered the final write pulse.
                        hold_q <= 1'b0;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        len_q[7:0] <= bus.rx_data;
                        state_q    <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        if (len_bad) begin
                            state_q    <= ERR;
                            err_q      <= 1'b1;
                            hold_q     <= 1'b0;
                            rx_ready_q <= 1'b0;
                        end else begin
                            len_q      <= len_d;
                            cnt_q      <= '0;
                            addr_q     <= BASE;
                            byte_cnt_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            csum_q     <= '0;
`endif
                            state_q    <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        shift_q    <= word_d;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q     <= csum_q ^ bus.rx_data;
`endif
                        if (byte_cnt_q == 2'd3) begin
                            we_q    <= 1'b1;
                            wdata_q <= word_d;
                            waddr_q <= addr_q;
                            addr_q  <= addr_q + 1'b1;
                            cnt_q   <= cnt_d;
                            if (cnt_d == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state_q <= CHECK;
`else
                                // hold_q stays high through the final pulse.
                                state_q    <= DONE;
                                done_q     <= 1'b1;
                                rx_ready_q <= 1'b0;
`endif
                            end
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (accept) begin
                        rx_ready_q <= 1'b0;
                        hold_q     <= 1'b0;
                        if (bus.rx_data == csum_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_q    <= IDLE;
                    rx_ready_q <= 1'b0;
                    hold_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_ready   = rx_ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = waddr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.cpu_hold   = hold_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 9, SHALL set the instruction-memory word-address width; MEM_SIZE = 2**ADDR_WIDTH words.
REQ-002 Parameter BASE_ADDR, default 0, SHALL set the first word address written.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 start  input  1  SHALL be a one-cycle request to begin a load session.
REQ-006 rx_valid  input  1  SHALL mark rx_data as valid.
REQ-007 rx_data  input  8  SHALL carry one byte of the load stream.
REQ-008 rx_ready  output  1  SHALL indicate the loader accepts a byte this cycle.
REQ-009 imem_we  output  1  SHALL be the instruction-memory write enable.
REQ-010 imem_addr  output  ADDR_WIDTH  SHALL be the word address being written.
REQ-011 imem_wdata  output  32  SHALL be the instruction word being written.
REQ-012 cpu_hold  output  1  SHALL hold the core's fetch stage in reset while loading.
REQ-013 done  output  1  SHALL flag a successfully completed session.
REQ-014 err  output  1  SHALL flag an aborted session.

Function
REQ-015 A byte SHALL be accepted only in a cycle where rx_valid and rx_ready are both 1.
REQ-016 Stream format SHALL be: LEN_LO, LEN_HI (16-bit word count N, little-endian), then N words of 4 bytes each, least-significant byte first.
REQ-017 FSM states SHALL be IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERR.
REQ-018 IDLE -> LEN_LO on start; start in any other state except DONE/ERR SHALL be ignored.
REQ-019 DONE or ERR -> LEN_LO on start; done and err SHALL clear in the same cycle.
REQ-020 rx_ready SHALL be 1 only in LEN_LO, LEN_HI, DATA and CHECK; bytes presented in other states SHALL be ignored.
REQ-021 LEN_HI accept: N=0 or N>MEM_SIZE SHALL go to ERR; otherwise go to DATA with word counter 0 and address BASE_ADDR.
REQ-022 DATA SHALL assemble bytes into a 32-bit shift register; on the 4th byte accepted, imem_we SHALL pulse high for exactly one cycle in the following cycle, with imem_wdata = assembled word and imem_addr = current address.
REQ-023 Address SHALL increment by one after each write, modulo MEM_SIZE (BASE_ADDR+N may wrap to 0).
REQ-024 After the Nth write the FSM SHALL go to DONE (CHECKSUM_EN undefined) or CHECK (defined).
REQ-025 Stall cycles (rx_valid=0) SHALL not alter any state; there is no timeout.
REQ-026 cpu_hold SHALL be 1 in LEN_LO, LEN_HI, DATA and CHECK and during the final imem_we pulse; 0 in IDLE, DONE and ERR.
REQ-027 done SHALL be 1 in DONE, err SHALL be 1 in ERR; both remain high until the next start or reset.
REQ-028 imem_we SHALL be 0 in every state except the write pulse of REQ-022.

Reset
REQ-029 rst SHALL asynchronously force IDLE, clear the byte shift register, word counter and address to BASE_ADDR, and drive rx_ready, imem_we, cpu_hold, done and err to 0 and imem_addr to BASE_ADDR and imem_wdata to 0.
REQ-030 rst mid-session SHALL abandon the session without any further imem_we pulse.

Configuration
REQ-031 Macro IMEM_LOADER_CHECKSUM_EN SHALL, when defined, enable state CHECK: one extra byte is accepted and compared with the XOR of all payload bytes (length bytes excluded); match -> DONE, mismatch -> ERR (words already written stay written).
REQ-032 Without IMEM_LOADER_CHECKSUM_EN, CHECK SHALL be unreachable and no checksum byte is consumed.

Verification
REQ-033 start; bytes 02 00, 13 05 A0 00, 93 05 10 00 -> imem_we pulses at addr 0 data 0x00A00513 and addr 1 data 0x00100593; done=1, cpu_hold=0.
REQ-034 Same stream with rx_valid low 3 cycles between every byte -> identical writes, no extra pulses.
REQ-035 Length bytes 00 00 -> err=1, no imem_we; length 01 02 (0x0201 > 512) -> err=1, no imem_we.
REQ-036 rst asserted after 2 of 4 words written -> all outputs 0 immediately, state IDLE, later bytes ignored (rx_ready=0).
REQ-037 With IMEM_LOADER_CHECKSUM_EN: 1 word 11 22 33 44 then checksum 44 -> done=1; checksum 45 -> err=1, word 0x44332211 written at addr 0.
REQ-038 BASE_ADDR=510, N=3 -> writes at addresses 510, 511, 0.
